// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//
// Purpose:
//   Producer side of the EXE-stage operand-forwarding interface, placed beside
//   the ID/EXE pipeline register. It tracks the destination tags of the
//   instructions in EXE and MEM. From those tags it produces registered operand
//   selects for the execute stage:
//     0 = val10 (register-file value)
//     1 = ALU_result_to_mem
//     2 = write_value_to_ID
//   It raises a combinational stall for load-use hazards and inserts a bubble
//   into EXE while the stall is active.
//
// Configuration:
//   FORWARDING_EN defined   : forwarding from EXE/MEM is enabled, and only
//                             load-use hazards stall.
//   FORWARDING_EN undefined : the selects stay at 0. Any read of a tracked
//                             destination (in EXE or MEM) stalls until the
//                             producer reaches WB.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   freeze        in   global pipeline hold; every register keeps its value
//   flush         in   branch taken; the ID instruction is squashed
//   id_valid      in   ID holds a real instruction
//   id_src1       in   rs index of the ID instruction
//   id_src2       in   rt index of the ID instruction
//   id_src2_used  in   src2 is a register (0 = immediate operand)
//   id_dest       in   destination index of the ID instruction
//   id_wb_en      in   ID instruction writes the register file
//   id_mem_read   in   ID instruction is a load
//   src1_mux      out  EXE operand-1 select (registered)
//   src2_mux      out  EXE operand-2 select (registered)
//   hazard_stall  out  combinational; hold PC and IF/ID, bubble EXE
//   stall_cnt     out  saturating count of stalled, non-frozen cycles

module forward_hazard_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_src1,
    input  logic [REG_ADDR_W-1:0]  id_src2,
    input  logic                   id_src2_used,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_wb_en,
    input  logic                   id_mem_read,
    output logic [1:0]             src1_mux,
    output logic [1:0]             src2_mux,
    output logic                   hazard_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Tag state for the instructions currently in EXE and MEM.
    logic                   exe_v_q, exe_v_d;
    logic [REG_ADDR_W-1:0]  exe_dest_q, exe_dest_d;
    logic                   exe_wb_q, exe_wb_d;
    logic                   exe_ld_q, exe_ld_d;
    logic                   mem_v_q, mem_v_d;
    logic [REG_ADDR_W-1:0]  mem_dest_q, mem_dest_d;
    logic                   mem_wb_q, mem_wb_d;
    logic [1:0]             src1_mux_q, src1_mux_d;
    logic [1:0]             src2_mux_q, src2_mux_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Tag matches. Register 0 is hard-wired, so it never produces a match.
    logic exe_m1, exe_m2, mem_m1, mem_m2;
    logic [1:0] sel1, sel2;
    logic stall;

    always_comb begin
        exe_m1 = exe_v_q & exe_wb_q & (exe_dest_q == id_src1) & (id_src1 != '0);
        exe_m2 = exe_v_q & exe_wb_q & (exe_dest_q == id_src2) & (id_src2 != '0)
                 & id_src2_used;
        mem_m1 = mem_v_q & mem_wb_q & (mem_dest_q == id_src1) & (id_src1 != '0);
        mem_m2 = mem_v_q & mem_wb_q & (mem_dest_q == id_src2) & (id_src2 != '0)
                 & id_src2_used;
    end

`ifdef FORWARDING_EN
    // The EXE tag is checked first, so the youngest producer wins when both
    // EXE and MEM write the same register.
    always_comb begin
        sel1 = 2'd0;
        sel2 = 2'd0;
        if (id_valid) begin
            if (exe_m1)      sel1 = 2'd1;
            else if (mem_m1) sel1 = 2'd2;
            if (exe_m2)      sel2 = 2'd1;
            else if (mem_m2) sel2 = 2'd2;
        end
    end

    // A load in EXE has no value until it reaches MEM, so its consumer waits
    // one cycle and then forwards from WB (select 2).
    assign stall = id_valid & exe_v_q & exe_ld_q & exe_wb_q & (exe_m1 | exe_m2);
`else
    assign sel1  = 2'd0;
    assign sel2  = 2'd0;
    assign stall = id_valid & (exe_m1 | exe_m2 | mem_m1 | mem_m2);
`endif

    assign hazard_stall = stall;

    always_comb begin
        // Default: every register holds (this is the freeze behaviour).
        exe_v_d     = exe_v_q;
        exe_dest_d  = exe_dest_q;
        exe_wb_d    = exe_wb_q;
        exe_ld_d    = exe_ld_q;
        mem_v_d     = mem_v_q;
        mem_dest_d  = mem_dest_q;
        mem_wb_d    = mem_wb_q;
        src1_mux_d  = src1_mux_q;
        src2_mux_d  = src2_mux_q;
        stall_cnt_d = stall_cnt_q;

        if (!freeze) begin
            // The MEM tag always advances from EXE when the pipeline moves.
            mem_v_d    = exe_v_q;
            mem_dest_d = exe_dest_q;
            mem_wb_d   = exe_wb_q;

            if (flush || stall) begin
                // Squash or bubble: EXE becomes empty. Flush takes priority,
                // so a stall that coincides with a flush is not counted.
                exe_v_d    = 1'b0;
                exe_dest_d = '0;
                exe_wb_d   = 1'b0;
                exe_ld_d   = 1'b0;
                src1_mux_d = 2'd0;
                src2_mux_d = 2'd0;
                if (!flush && (stall_cnt_q != '1)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end else begin
                exe_v_d    = id_valid;
                exe_dest_d = id_dest;
                exe_wb_d   = id_wb_en;
                exe_ld_d   = id_mem_read;
                src1_mux_d = sel1;
                src2_mux_d = sel2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_v_q     <= 1'b0;
            exe_dest_q  <= '0;
            exe_wb_q    <= 1'b0;
            exe_ld_q    <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
            src1_mux_q  <= 2'd0;
            src2_mux_q  <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            exe_v_q     <= exe_v_d;
            exe_dest_q  <= exe_dest_d;
            exe_wb_q    <= exe_wb_d;
            exe_ld_q    <= exe_ld_d;
            mem_v_q     <= mem_v_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_q    <= mem_wb_d;
            src1_mux_q  <= src1_mux_d;
            src2_mux_q  <= src2_mux_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign src1_mux  = src1_mux_q;
    assign src2_mux  = src2_mux_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Testbench for forward_hazard_unit.
// Each row drives one cycle of ID-stage inputs. The bench checks hazard_stall
// before the clock edge, and it checks src1_mux, src2_mux and stall_cnt after
// the edge. Expected post-edge values go through a queue between driving the
// inputs and sampling the outputs. Expectations are written by hand for the
// build selected by FORWARDING_EN.

module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n, freeze, flush;
    logic       id_valid, id_src2_used, id_wb_en, id_mem_read;
    logic [4:0] id_src1, id_src2, id_dest;
    logic [1:0] src1_mux, src2_mux;
    logic       hazard_stall;
    logic [15:0] stall_cnt;

    forward_hazard_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .src1_mux(src1_mux), .src2_mux(src2_mux),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n, frz, fl, val;
        int s1, s2;
        bit used;
        int d;
        bit wb, ld;
        bit st;
        int m1, m2, cnt;
    } vec_t;

    typedef struct {
        int m1, m2, cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int row   = 0;

    function automatic vec_t v(bit r, bit frz, bit fl, bit val, int s1, int s2,
                               bit used, int d, bit wb, bit ld,
                               bit st, int m1, int m2, int cnt);
        vec_t x;
        x.rst_n = r; x.frz = frz; x.fl = fl; x.val = val;
        x.s1 = s1; x.s2 = s2; x.used = used; x.d = d; x.wb = wb; x.ld = ld;
        x.st = st; x.m1 = m1; x.m2 = m2; x.cnt = cnt;
        return x;
    endfunction

    // Normal-running instruction helpers: rd, rs, rt
    function automatic vec_t alu(int d, int s1, int s2, bit st, int m1, int m2, int cnt);
        return v(1, 0, 0, 1, s1, s2, 1, d, 1, 0, st, m1, m2, cnt);
    endfunction

    function automatic vec_t lw(int d, int s1, bit st, int m1, int cnt);
        return v(1, 0, 0, 1, s1, 0, 0, d, 1, 1, st, m1, 0, cnt);
    endfunction

    task automatic run_row(input vec_t r);
        exp_t e;
        @(negedge clk);
        rst_n        = r.rst_n;
        freeze       = r.frz;
        flush        = r.fl;
        id_valid     = r.val;
        id_src1      = 5'(r.s1);
        id_src2      = 5'(r.s2);
        id_src2_used = r.used;
        id_dest      = 5'(r.d);
        id_wb_en     = r.wb;
        id_mem_read  = r.ld;
        #1;
        n_cmp++;
        if (hazard_stall !== r.st) begin
            n_err++;
            $display("FAIL row%0d hazard_stall: got %b expected %b", row, hazard_stall, r.st);
        end
        e.m1 = r.m1; e.m2 = r.m2; e.cnt = r.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp += 3;
        if (src1_mux !== 2'(e.m1)) begin
            n_err++;
            $display("FAIL row%0d src1_mux: got %0d expected %0d", row, src1_mux, e.m1);
        end
        if (src2_mux !== 2'(e.m2)) begin
            n_err++;
            $display("FAIL row%0d src2_mux: got %0d expected %0d", row, src2_mux, e.m2);
        end
        if (stall_cnt !== 16'(e.cnt)) begin
            n_err++;
            $display("FAIL row%0d stall_cnt: got %0d expected %0d", row, stall_cnt, e.cnt);
        end
        $display("row%0d rst_n=%b frz=%b fl=%b v=%b s1=%0d s2=%0d d=%0d : stall=%b m1=%0d m2=%0d cnt=%0d",
                 row, r.rst_n, r.frz, r.fl, r.val, r.s1, r.s2, r.d,
                 hazard_stall, src1_mux, src2_mux, stall_cnt);
        row++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; freeze = 0; flush = 0; id_valid = 0; id_src1 = 0; id_src2 = 0;
        id_src2_used = 0; id_dest = 0; id_wb_en = 0; id_mem_read = 0;
        repeat (2) @(posedge clk);

        // Reset row (checked), then simple instruction streams
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef FORWARDING_EN
        tbl.push_back(alu(3, 1, 2,   0, 0, 0, 0));  // add r3,r1,r2
        tbl.push_back(alu(4, 3, 5,   0, 1, 0, 0));  // add r4,r3,r5 -> src1 from EXE
        tbl.push_back(alu(6, 7, 3,   0, 0, 2, 0));  // sub r6,r7,r3 -> src2 from MEM
        tbl.push_back(alu(3, 0, 0,   0, 0, 0, 0));  // older r3
        tbl.push_back(alu(3, 1, 1,   0, 0, 0, 0));  // younger r3
        tbl.push_back(alu(10, 3, 3,  0, 1, 1, 0));  // youngest producer wins
        tbl.push_back(lw(8, 0,       0, 0, 0));     // lw r8
        tbl.push_back(alu(9, 8, 8,   1, 0, 0, 1));  // load-use: bubble
        tbl.push_back(alu(9, 8, 8,   0, 2, 2, 1));  // replay: forward from WB
        tbl.push_back(alu(0, 1, 1,   0, 0, 0, 1));  // writes r0
        tbl.push_back(alu(11, 0, 0,  0, 0, 0, 1));  // reads r0: never forwarded
        tbl.push_back(v(1, 0, 0, 1, 1, 11, 0, 12, 1, 0, 0, 0, 0, 1)); // immediate src2=r11
`else
        tbl.push_back(alu(3, 1, 2,   0, 0, 0, 0));  // add r3
        tbl.push_back(alu(4, 3, 5,   1, 0, 0, 1));  // r3 in EXE: stall
        tbl.push_back(alu(4, 3, 5,   1, 0, 0, 2));  // r3 in MEM: stall
        tbl.push_back(alu(4, 3, 5,   0, 0, 0, 2));  // r3 in WB: proceed
        tbl.push_back(alu(0, 1, 1,   0, 0, 0, 2));  // writes r0
        tbl.push_back(alu(11, 0, 0,  0, 0, 0, 2));  // reads r0: no stall
        tbl.push_back(v(1, 0, 0, 1, 1, 11, 0, 12, 1, 0, 0, 0, 0, 2)); // immediate src2=r11
`endif
        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i]);

        // Multi-cycle corner sequences: freeze during load-use, flush over
        // stall, reset mid-stall, id_valid=0 with matching indices.
`ifdef FORWARDING_EN
        run_row(lw(13, 12,           0, 1, 1));             // src1 from r12 in EXE
        for (int k = 0; k < 3; k++)
            run_row(v(1, 1, 0, 1, 13, 1, 1, 14, 1, 0, 1, 1, 0, 1)); // frozen
        run_row(alu(14, 13, 1,       1, 0, 0, 2));          // stall counts now
        run_row(alu(14, 13, 1,       0, 2, 0, 2));
        run_row(lw(15, 0,            0, 0, 2));
        run_row(v(1, 0, 1, 1, 15, 15, 1, 16, 1, 0, 1, 0, 0, 2)); // flush beats stall
        run_row(alu(17, 15, 2,       0, 2, 0, 2));          // stall cleared
        run_row(lw(18, 17,           0, 1, 2));
        run_row(v(0, 0, 0, 1, 18, 0, 1, 19, 1, 0, 1, 0, 0, 0)); // reset mid-stall
        run_row(alu(19, 18, 0,       0, 0, 0, 0));
        run_row(v(1, 0, 0, 0, 19, 19, 1, 20, 1, 1, 0, 0, 0, 0)); // invalid ID
`else
        run_row(lw(13, 0,            0, 0, 2));
        for (int k = 0; k < 2; k++)
            run_row(v(1, 1, 0, 1, 13, 1, 1, 14, 1, 0, 1, 0, 0, 2)); // frozen
        run_row(alu(14, 13, 1,       1, 0, 0, 3));
        run_row(alu(14, 13, 1,       1, 0, 0, 4));
        run_row(alu(14, 13, 1,       0, 0, 0, 4));
        run_row(v(1, 0, 1, 1, 14, 0, 1, 16, 1, 0, 1, 0, 0, 4)); // flush beats stall
        run_row(alu(17, 2, 2,        0, 0, 0, 4));
        run_row(v(0, 0, 0, 1, 17, 0, 1, 19, 1, 0, 1, 0, 0, 0)); // reset mid-stall
        run_row(alu(19, 17, 0,       0, 0, 0, 0));
        run_row(v(1, 0, 0, 0, 19, 19, 1, 20, 1, 0, 0, 0, 0, 0)); // invalid ID
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
